// File: rtl/pixel_readout_serializer.sv
// Pixel readout serializer: buffers 32-bit databus words in a FIFO and streams pixels one byte per cycle with sof/eof.
// Optional build macro READOUT_GRAY_DECODE_EN: Gray-to-binary decode each pixel byte on the way out.
module pixel_readout_serializer #(
    parameter int DEPTH       = 4,
    parameter int FRAME_WORDS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] LAST_WORD  = WW'(FRAME_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef READOUT_GRAY_DECODE_EN
    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    state_t         state_q, state_d;
    logic [31:0]    hold_q, hold_d;
    logic [1:0]     idx_q, idx_d;
    logic [WW-1:0]  cur_word_q, cur_word_d;
    logic [WW-1:0]  next_word_q, next_word_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]    fifo_mem_q [DEPTH];
    logic [31:0]    fifo_mem_d [DEPTH];
    logic           overflow_q, overflow_d;

    logic [AW:0]    fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic [31:0]    fifo_head;
    logic [7:0]     cur_byte;

    // FIFO occupancy, write acceptance and sticky overflow
    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == FULL_COUNT);
        push       = in_valid & ~fifo_full;
        fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
        overflow_d = overflow_q | (in_valid & fifo_full);
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end else begin
            fifo_mem_d = fifo_mem_q;
        end
    end

    // Serializer next state: word load from FIFO head, byte stepping on handshake
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        cur_word_d  = cur_word_q;
        next_word_d = next_word_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (out_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A load always starts at byte 0 and takes the next frame word slot
        if (pop) begin
            hold_d     = fifo_head;
            idx_d      = 2'd0;
            cur_word_d = next_word_q;
            if (next_word_q == LAST_WORD) begin
                next_word_d = '0;
            end else begin
                next_word_d = next_word_q + WW'(1);
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // State, datapath and FIFO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= 32'd0;
            idx_q       <= 2'd0;
            cur_word_q  <= '0;
            next_word_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            cur_word_q  <= cur_word_d;
            next_word_q <= next_word_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

    // Outputs are pure functions of registered state, so they hold while stalled
    always_comb begin
        cur_byte  = hold_q[{idx_q, 3'b000} +: 8];
`ifdef READOUT_GRAY_DECODE_EN
        out_data  = gray_to_bin(cur_byte);
`else
        out_data  = cur_byte;
`endif
        out_valid = (state_q == ST_SHIFT);
        out_sof   = (state_q == ST_SHIFT) && (cur_word_q == '0) && (idx_q == 2'd0);
        out_eof   = (state_q == ST_SHIFT) && (cur_word_q == LAST_WORD) && (idx_q == 2'd3);
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_pixel_readout_serializer.sv
// Directed self-checking bench for pixel_readout_serializer (FRAME_WORDS=1 and FRAME_WORDS=2 instances).
module tb_pixel_readout_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;

    logic [7:0] o1_data, o2_data;
    logic       o1_valid, o2_valid, o1_sof, o2_sof, o1_eof, o2_eof, o1_ovf, o2_ovf;

    bit         use2 = 1'b0;
    logic [7:0] mo_data;
    logic       mo_valid, mo_sof, mo_eof, mo_ovf;

    int total = 0;
    int bad = 0;

    logic [7:0] got_data[$];
    bit         got_sof[$];
    bit         got_eof[$];
    int         last_bubbles;

    always #5 clk = ~clk;

    pixel_readout_serializer #(.DEPTH(4), .FRAME_WORDS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_data(o1_data), .out_valid(o1_valid), .out_ready(out_ready),
        .out_sof(o1_sof), .out_eof(o1_eof), .overflow(o1_ovf)
    );

    pixel_readout_serializer #(.DEPTH(4), .FRAME_WORDS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_data(o2_data), .out_valid(o2_valid), .out_ready(out_ready),
        .out_sof(o2_sof), .out_eof(o2_eof), .overflow(o2_ovf)
    );

    assign mo_data  = use2 ? o2_data  : o1_data;
    assign mo_valid = use2 ? o2_valid : o1_valid;
    assign mo_sof   = use2 ? o2_sof   : o1_sof;
    assign mo_eof   = use2 ? o2_eof   : o1_eof;
    assign mo_ovf   = use2 ? o2_ovf   : o1_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected pixel on out_data for a raw stored byte
    function automatic logic [7:0] exp_pix(input logic [7:0] raw);
`ifdef READOUT_GRAY_DECODE_EN
        logic [7:0] b;
        logic acc;
        acc = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            acc  = acc ^ raw[i];
            b[i] = acc;
        end
        return b;
`else
        return raw;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Collect up to 'want' handshakes; toggle selects ready pattern 1,0,0,1 repeating
    task automatic drain(input int want, input int budget, input bit toggle);
        logic [3:0] pat;
        int cyc;
        bit stall, started;
        logic [7:0] pd;
        logic ps, pe;
        pat = 4'b1001;
        cyc = 0; stall = 0; started = 0; last_bubbles = 0;
        pd = 8'd0; ps = 1'b0; pe = 1'b0;
        got_data.delete(); got_sof.delete(); got_eof.delete();
        while (got_data.size() < want && cyc < budget) begin
            if (stall) begin
                check_val("hold_data", mo_data, pd);
                check_val("hold_sof", mo_sof, ps);
                check_val("hold_eof", mo_eof, pe);
            end
            out_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (mo_valid && out_ready) begin
                got_data.push_back(mo_data);
                got_sof.push_back(mo_sof);
                got_eof.push_back(mo_eof);
                started = 1;
            end else if (started && !mo_valid) begin
                last_bubbles++;
            end
            stall = mo_valid && !out_ready;
            pd = mo_data; ps = mo_sof; pe = mo_eof;
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        check_val("drain_count", got_data.size(), want);
    endtask

    initial begin
        logic [7:0] single [4];
        logic [7:0] w;
        single[0] = 8'h11; single[1] = 8'h22; single[2] = 8'h33; single[3] = 8'h44;

        // Reset values
        do_reset();
        check_val("rst_valid", o1_valid, 0);
        check_val("rst_data", o1_data, 0);
        check_val("rst_sof", o1_sof, 0);
        check_val("rst_eof", o1_eof, 0);
        check_val("rst_ovf", o1_ovf, 0);

        // Single word: valid from edge N+1 through N+4
        in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("lat_edge_n", o1_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_val("single_valid", o1_valid, 1);
            check_val("single_data", o1_data, exp_pix(single[k]));
            check_val("single_sof", o1_sof, k == 0);
            check_val("single_eof", o1_eof, k == 3);
        end
        @(posedge clk); #1;
        check_val("single_end", o1_valid, 0);

        // Back-pressure
        do_reset();
        push_word(32'h44332211);
        drain(4, 40, 1'b1);
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            check_val("bp_data", got_data[k], exp_pix(single[k]));
        end
        check_val("bp_end", o1_valid, 0);

        // Overflow: word 1 goes straight to the holding register, words 2..5 fill the FIFO, word 6 drops
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            push_word(32'h01010101 * i);
            check_val("ovf_flag", o1_ovf, i == 6);
        end
        drain(20, 60, 1'b0);
        for (int j = 0; j < got_data.size(); j++) begin
            w = 8'(j / 4 + 1);
            check_val("ovf_data", got_data[j], exp_pix(w));
        end
        check_val("ovf_end", o1_valid, 0);
        check_val("ovf_sticky", o1_ovf, 1);

        // Frame markers with FRAME_WORDS=2
        do_reset();
        use2 = 1'b1;
        for (int wd = 0; wd < 4; wd++) begin
            push_word({8'(4*wd+3), 8'(4*wd+2), 8'(4*wd+1), 8'(4*wd)});
        end
        drain(16, 60, 1'b0);
        for (int j = 0; j < got_data.size(); j++) begin
            check_val("frm_data", got_data[j], exp_pix(8'(j)));
            check_val("frm_sof", got_sof[j], (j == 0) || (j == 8));
            check_val("frm_eof", got_eof[j], (j == 7) || (j == 15));
        end
        check_val("frm_bubbles", last_bubbles, 0);
        use2 = 1'b0;

        // Reset mid-frame, with overflow set beforehand
        do_reset();
        for (int i = 1; i <= 7; i++) push_word(32'h44332211);
        check_val("mid_ovf_pre", o1_ovf, 1);
        drain(2, 20, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("mid_valid", o1_valid, 0);
        check_val("mid_ovf", o1_ovf, 0);
        push_word(32'hDDCCBBAA);
        drain(4, 20, 1'b0);
        if (got_data.size() == 4) begin
            check_val("mid_b0", got_data[0], exp_pix(8'hAA));
            check_val("mid_sof", got_sof[0], 1);
            check_val("mid_b3", got_data[3], exp_pix(8'hDD));
            check_val("mid_eof", got_eof[3], 1);
        end

        // Gray decode word
        do_reset();
        push_word(32'h80C0A0FF);
        drain(4, 20, 1'b0);
        if (got_data.size() == 4) begin
`ifdef READOUT_GRAY_DECODE_EN
            check_val("gray_b0", got_data[0], 8'hAA);
            check_val("gray_b1", got_data[1], 8'hC0);
            check_val("gray_b2", got_data[2], 8'h80);
            check_val("gray_b3", got_data[3], 8'hFF);
`else
            check_val("raw_b0", got_data[0], 8'hFF);
            check_val("raw_b1", got_data[1], 8'hA0);
            check_val("raw_b2", got_data[2], 8'hC0);
            check_val("raw_b3", got_data[3], 8'h80);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
